// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Round-robin arbiter and sequencer that lets two masters share the single
// port of a synchronous memory with registered read data. It makes at most
// one access per cycle. A master can hold ownership for a bounded number of
// consecutive grants, which allows atomic read-modify-write sequences.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   mX_req_i              access request, held until granted
//   mX_we_i               1 = write, 0 = read
//   mX_addr_i/wdata_i     access address / write data
//   mX_lock_i             keep ownership after this access
//   mX_gnt_o              combinational grant (access accepted this cycle)
//   mX_rvalid_o           read data valid (cycle after a read grant)
//   mX_rdata_o            read data, meaningful only while mX_rvalid_o is high
//   mem_*_o / mem_rdata_i memory-side port
module mem_port_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    input  logic                  m0_lock_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [WIDTH-1:0]      m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    input  logic                  m1_lock_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    localparam int unsigned CntWidth = $clog2(LOCK_MAX + 1);
    localparam logic [CntWidth-1:0] LockMaxC = CntWidth'(LOCK_MAX);

    typedef enum logic [1:0] {
        StArb,
        StOwn0,
        StOwn1
    } state_e;

    state_e                r_state, w_state_next;
    logic                  r_rr_ptr, w_rr_next;
    logic [CntWidth-1:0]   r_lock_cnt, w_lock_cnt_next;
    logic [1:0]            r_rd_tag, w_rd_tag_next;
    logic [CntWidth-1:0]   w_cnt_inc;
    logic                  w_gnt0, w_gnt1;

    assign w_cnt_inc = r_lock_cnt + CntWidth'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StArb;
            r_rr_ptr   <= 1'b0;
            r_lock_cnt <= '0;
            r_rd_tag   <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_next;
            r_lock_cnt <= w_lock_cnt_next;
            r_rd_tag   <= w_rd_tag_next;
        end
    end

    always_comb begin
        w_gnt0          = 1'b0;
        w_gnt1          = 1'b0;
        w_state_next    = r_state;
        w_rr_next       = r_rr_ptr;
        w_lock_cnt_next = r_lock_cnt;
        // Reset blocks every grant so no access leaks out during a reset cycle.
        if (!rst_i) begin
            unique case (r_state)
                StArb: begin
                    // rr_ptr only matters on a tie.
                    if (m0_req_i && (!m1_req_i || !r_rr_ptr)) begin
                        w_gnt0    = 1'b1;
                        w_rr_next = 1'b1;
                        if (m0_lock_i) begin
                            w_state_next    = StOwn0;
                            w_lock_cnt_next = CntWidth'(1);
                        end
                    end else if (m1_req_i) begin
                        w_gnt1    = 1'b1;
                        w_rr_next = 1'b0;
                        if (m1_lock_i) begin
                            w_state_next    = StOwn1;
                            w_lock_cnt_next = CntWidth'(1);
                        end
                    end
                end
                StOwn0: begin
                    if (!m0_req_i) begin
                        w_state_next    = StArb;
                        w_lock_cnt_next = '0;
                    end else begin
                        w_gnt0 = 1'b1;
                        if (m0_lock_i && (w_cnt_inc < LockMaxC)) begin
                            w_lock_cnt_next = w_cnt_inc;
                        end else begin
                            w_state_next    = StArb;
                            w_lock_cnt_next = '0;
                            w_rr_next       = 1'b1;
                        end
                    end
                end
                StOwn1: begin
                    if (!m1_req_i) begin
                        w_state_next    = StArb;
                        w_lock_cnt_next = '0;
                    end else begin
                        w_gnt1 = 1'b1;
                        if (m1_lock_i && (w_cnt_inc < LockMaxC)) begin
                            w_lock_cnt_next = w_cnt_inc;
                        end else begin
                            w_state_next    = StArb;
                            w_lock_cnt_next = '0;
                            w_rr_next       = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_next    = StArb;
                    w_lock_cnt_next = '0;
                end
            endcase
        end
    end

    // The grants are mutually exclusive, so a priority mux is enough.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_gnt0) begin
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (w_gnt1) begin
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    assign mem_wr_en_o   = (w_gnt0 & m0_we_i) | (w_gnt1 & m1_we_i);
    assign mem_rd_en_o   = (w_gnt0 & ~m0_we_i) | (w_gnt1 & ~m1_we_i);
    assign w_rd_tag_next = {w_gnt1 & ~m1_we_i, w_gnt0 & ~m0_we_i};

    assign m0_gnt_o = w_gnt0;
    assign m1_gnt_o = w_gnt1;

    // The read tag is registered. Gating it with rst_i drops an rvalid that is
    // pending in a reset cycle, and it forces every output to zero during reset.
    assign m0_rvalid_o = r_rd_tag[0] & ~rst_i;
    assign m1_rvalid_o = r_rd_tag[1] & ~rst_i;
    assign m0_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign m1_rdata_o  = rst_i ? '0 : mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory sits behind the DUT,
// grant sequences come from a vector table, and read returns are scored
// against a queue of expected {master, data} entries.
module tb_mem_port_arbiter;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned LOCK_MAX   = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                  rst_i;
    logic                  m0_req_i, m0_we_i, m0_lock_i, m0_gnt_o, m0_rvalid_o;
    logic [ADDR_WIDTH-1:0] m0_addr_i;
    logic [WIDTH-1:0]      m0_wdata_i, m0_rdata_o;
    logic                  m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_rvalid_o;
    logic [ADDR_WIDTH-1:0] m1_addr_i;
    logic [WIDTH-1:0]      m1_wdata_i, m1_rdata_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wdata_o, mem_rdata_i;
    logic                  mem_wr_en_o, mem_rd_en_o;

    mem_port_arbiter #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LOCK_MAX   (LOCK_MAX)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_lock_i   (m0_lock_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_lock_i   (m1_lock_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Behavioural single-port memory with registered read data.
    logic [WIDTH-1:0] env_mem [256] = '{default: 16'h0};
    logic [WIDTH-1:0] env_rdata = '0;
    assign mem_rdata_i = env_rdata;
    always @(posedge clk_i) begin
        if (mem_wr_en_o) env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
        if (mem_rd_en_o) env_rdata <= env_mem[mem_addr_o[7:0]];
    end

    typedef struct {
        logic             rst;
        logic             r0, w0, l0;
        logic [15:0]      a0, d0;
        logic             r1, w1, l1;
        logic [15:0]      a1, d1;
        logic             g0, g1;
    } vec_t;

    typedef struct {
        logic        m;
        logic [15:0] data;
    } rd_t;

    vec_t        vq[$];
    rd_t         sb[$];
    logic [15:0] exp_mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait0    = 0;
    int          wait1    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst,
                       input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1,
                       input logic g0, input logic g1);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst_i     = v.rst;
        m0_req_i  = v.r0; m0_we_i = v.w0; m0_lock_i = v.l0;
        m0_addr_i = v.a0; m0_wdata_i = v.d0;
        m1_req_i  = v.r1; m1_we_i = v.w1; m1_lock_i = v.l1;
        m1_addr_i = v.a1; m1_wdata_i = v.d1;
    endtask

    // Called once per cycle at the falling edge.
    task automatic monitor();
        rd_t              e;
        logic             exp_rv0, exp_rv1;
        logic [15:0]      exp_d, ea, ed;
        logic             ew, er;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_d   = '0;
        if (rst_i) begin
            sb.delete();
            wait0 = 0;
            wait1 = 0;
            check("rst_ctrl", {58'd0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                  mem_wr_en_o, mem_rd_en_o}, 64'd0);
            check("rst_data", {m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o}, 64'd0);
            return;
        end
        if (sb.size() > 0) begin
            e       = sb.pop_front();
            exp_rv0 = ~e.m;
            exp_rv1 = e.m;
            exp_d   = e.data;
        end
        check("rvalid0", {63'd0, m0_rvalid_o}, {63'd0, exp_rv0});
        check("rvalid1", {63'd0, m1_rvalid_o}, {63'd0, exp_rv1});
        if (exp_rv0) check("rdata0", {48'd0, m0_rdata_o}, {48'd0, exp_d});
        if (exp_rv1) check("rdata1", {48'd0, m1_rdata_o}, {48'd0, exp_d});
        check("one_gnt", {63'd0, m0_gnt_o & m1_gnt_o}, 64'd0);
        check("gnt_without_req", {63'd0, (m0_gnt_o & ~m0_req_i) | (m1_gnt_o & ~m1_req_i)},
              64'd0);
        check("en_exclusive", {63'd0, mem_wr_en_o & mem_rd_en_o}, 64'd0);
        ea = m0_gnt_o ? m0_addr_i  : (m1_gnt_o ? m1_addr_i  : 16'h0);
        ed = m0_gnt_o ? m0_wdata_i : (m1_gnt_o ? m1_wdata_i : 16'h0);
        ew = (m0_gnt_o & m0_we_i) | (m1_gnt_o & m1_we_i);
        er = (m0_gnt_o & ~m0_we_i) | (m1_gnt_o & ~m1_we_i);
        check("mem_drive", {30'd0, mem_addr_o, mem_wdata_o, mem_wr_en_o, mem_rd_en_o},
              {30'd0, ea, ed, ew, er});
        wait0 = (m0_req_i && !m0_gnt_o) ? wait0 + 1 : 0;
        wait1 = (m1_req_i && !m1_gnt_o) ? wait1 + 1 : 0;
        check("wait0_bound", {63'd0, wait0 > int'(LOCK_MAX)}, 64'd0);
        check("wait1_bound", {63'd0, wait1 > int'(LOCK_MAX)}, 64'd0);
        if (m0_gnt_o) begin
            if (m0_we_i) exp_mem[m0_addr_i[7:0]] = m0_wdata_i;
            else sb.push_back('{m: 1'b0, data: exp_mem[m0_addr_i[7:0]]});
        end
        if (m1_gnt_o) begin
            if (m1_we_i) exp_mem[m1_addr_i[7:0]] = m1_wdata_i;
            else sb.push_back('{m: 1'b1, data: exp_mem[m1_addr_i[7:0]]});
        end
    endtask

    initial begin
        logic pg0, pg1;
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;
        //   rst r0 w0 l0 a0  d0       r1 w1 l1 a1  d1       g0 g1
        add(1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    0, 0);
        add(1, 1, 0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    0, 0);
        // single master: write then read back the same address
        add(0, 1, 1, 0, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0,    1, 0);
        add(0, 1, 0, 0, 3, 16'h0,    0, 0, 0, 0, 16'h0,    1, 0);
        add(0, 0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0, 0);
        // preload contention addresses
        add(0, 1, 1, 0, 1, 16'h1111, 0, 0, 0, 0, 16'h0,    1, 0);
        add(0, 0, 0, 0, 0, 16'h0,    1, 1, 0, 2, 16'h2222, 0, 1);
        // contention from reset: m0 first, then alternation
        add(1, 1, 0, 0, 1, 16'h0,    1, 0, 0, 2, 16'h0,    0, 0);
        for (int i = 0; i < 6; i++)
            add(0, 1, 0, 0, 1, 16'h0, 1, 0, 0, 2, 16'h0, 1'(i % 2 == 0), 1'(i % 2 == 1));
        // point rr at m1, then m1 locks for 6 cycles against a busy m0
        add(0, 1, 0, 0, 1, 16'h0,    0, 0, 0, 0, 16'h0,    1, 0);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    1, 0);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 1, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 0, 2, 16'h0,    0, 1);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 0, 2, 16'h0,    1, 0);
        // m0 locks, then drops req while m1 waits
        add(0, 1, 0, 1, 5, 16'h0,    0, 0, 0, 0, 16'h0,    1, 0);
        add(0, 0, 0, 0, 0, 16'h0,    1, 0, 0, 2, 16'h0,    0, 0);
        add(0, 1, 0, 0, 1, 16'h0,    1, 0, 0, 2, 16'h0,    0, 1);
        // reset in the cycle after a read grant
        add(0, 1, 0, 0, 3, 16'h0,    0, 0, 0, 0, 16'h0,    1, 0);
        add(1, 1, 0, 0, 3, 16'h0,    1, 0, 0, 2, 16'h0,    0, 0);
        add(0, 1, 0, 0, 3, 16'h0,    1, 0, 0, 2, 16'h0,    1, 0);
        add(0, 0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0, 0);

        drive(vq[0]);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk_i);
            monitor();
            check($sformatf("vec%0d_gnt0", i), {63'd0, m0_gnt_o}, {63'd0, vq[i].g0});
            check($sformatf("vec%0d_gnt1", i), {63'd0, m1_gnt_o}, {63'd0, vq[i].g1});
            @(posedge clk_i);
            #1;
        end

        // Random traffic; a master changes its request only when idle or just granted.
        pg0 = 1'b1;
        pg1 = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            rst_i = ($urandom_range(0, 999) == 0);
            if (!m0_req_i || pg0) begin
                m0_req_i   = ($urandom_range(0, 3) != 0);
                m0_we_i    = 1'($urandom_range(0, 1));
                m0_lock_i  = 1'($urandom_range(0, 1));
                m0_addr_i  = 16'($urandom_range(0, 15));
                m0_wdata_i = 16'($urandom);
            end
            if (!m1_req_i || pg1) begin
                m1_req_i   = ($urandom_range(0, 3) != 0);
                m1_we_i    = 1'($urandom_range(0, 1));
                m1_lock_i  = 1'($urandom_range(0, 1));
                m1_addr_i  = 16'($urandom_range(0, 15));
                m1_wdata_i = 16'($urandom);
            end
            @(negedge clk_i);
            monitor();
            pg0 = m0_gnt_o;
            pg1 = m1_gnt_o;
            @(posedge clk_i);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port synchronous `memory` block (WIDTH×DEPTH array with registered read data). It accepts independent access requests from master 0 and master 1 and issues at most one access per cycle on the memory's addr/wdata/wr_en/rd_en port. Read data is routed back to the issuing master with a one-cycle valid strobe. Arbitration is round-robin, with an optional bounded lock so that one master can perform atomic read-modify-write sequences.

## Interface
Parameters:
- WIDTH, 16, data width; must equal the memory instance's WIDTH
- ADDR_WIDTH, 16, address width; must equal the memory instance's ADDR_WIDTH
- LOCK_MAX, 4, maximum consecutive grants one master may hold under lock (≥2)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- m0_req_i / m1_req_i  in  1  access request, held until granted
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  access address
- m0_wdata_i / m1_wdata_i  in  WIDTH  write data
- m0_lock_i / m1_lock_i  in  1  request that ownership continue after this access
- m0_gnt_o / m1_gnt_o  out  1  combinational; access accepted this cycle
- m0_rvalid_o / m1_rvalid_o  out  1  registered; read data valid this cycle
- m0_rdata_o / m1_rdata_o  out  WIDTH  both driven from mem_rdata_i; meaningful only while the matching rvalid is high
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i
- mem_wdata_o  out  WIDTH  to memory wdata_i
- mem_wr_en_o  out  1  to memory wr_en_i
- mem_rd_en_o  out  1  to memory rd_en_i
- mem_rdata_i  in  WIDTH  from memory rdata_o

## Operation
- State machine states:
  - ARB: free arbitration.
  - OWN0 / OWN1: master 0 or master 1 holds a lock.
- State registers:
  - rr_ptr (1 bit): master that wins a tie.
  - lock_cnt: number of grants taken in the current ownership, clog2(LOCK_MAX+1) bits.
  - rd_tag: 2 bits, one-hot per master, records the pending read.
- Grant rules in ARB:
  - Only one request asserted: that master is granted.
  - Both requests asserted: the master selected by rr_ptr is granted.
  - After any ARB grant, rr_ptr points to the other master.
- Locking from ARB: if the granted access has lock_i=1, the next state is OWNx and lock_cnt=1. Otherwise the state stays ARB.
- Grant rules in OWNx:
  - Only master x can be granted. The other master's gnt_o is 0 regardless of its req.
  - Owner req_i=0: no grant; return to ARB; lock_cnt=0.
  - Owner req_i=1: grant. If lock_i=1 and lock_cnt+1 < LOCK_MAX, stay in OWNx and increment lock_cnt. Otherwise return to ARB, set lock_cnt=0, and point rr_ptr at the other master.
  - Result: at most LOCK_MAX consecutive grants to one master while the other is waiting.
- Memory drive (combinational from the grant decision):
  - mem_addr_o and mem_wdata_o come from the granted master.
  - mem_wr_en_o = gnt & we.
  - mem_rd_en_o = gnt & ~we.
  - With no grant, all four memory-side outputs are 0.
  - mem_wr_en_o and mem_rd_en_o are never high in the same cycle.
- Read return: rd_tag is set to the granted master on a read grant and cleared otherwise. mX_rvalid_o = rd_tag[X].

## Timing
- Reset (synchronous): state=ARB, rr_ptr=0 (master 0 wins the first tie), lock_cnt=0, rd_tag=0.
  - Reset value of every output is 0.
  - rst_i overrides requests: no grant and no memory enable during a reset cycle.
  - Any pending rvalid is dropped.
  - Reset asserted mid-lock releases the lock.
- Grant latency: 0 cycles. gnt_o is asserted in the same cycle as req_i when the master wins, and the memory samples the access at the following edge.
- Read latency: rvalid_o is high exactly in cycle N+1 for a read granted in cycle N. Data equals mem[addr] including any write granted in an earlier cycle.
- Throughput: one access per cycle. Back-to-back reads produce back-to-back rvalid pulses, possibly alternating between masters.
- A request not granted is stalled. The master holds req/we/addr/wdata/lock stable until gnt_o.
- Write followed by read to the same address in the next cycle returns the new data.

## Test plan
- Single master:
  - Stimulus: m0 writes 0xBEEF to addr 3 (cycle 0), then reads addr 3 (cycle 1).
  - Required response: m0_gnt_o=1 in both cycles, mem_wr_en_o high in cycle 0 only, m0_rvalid_o=1 in cycle 2 with m0_rdata_o=0xBEEF, m1_rvalid_o=0 throughout.
- Contention:
  - Stimulus: both masters request reads continuously from reset, m0 to addr 1 and m1 to addr 2.
  - Required response: grants alternate m0, m1, m0, ... starting with m0. rvalid pulses alternate one cycle later with the matching data.
- Lock:
  - Stimulus: m1 requests with lock=1 for 6 cycles while m0 requests continuously, LOCK_MAX=4.
  - Required response: m1 is granted 4 consecutive cycles, then m0 is granted on the 5th, after which alternation resumes.
- Lock release:
  - Stimulus: m0 locks, then drops req for one cycle while m1 is requesting.
  - Required response: no grant in that cycle, state returns to ARB, and m1 is granted in the following cycle.
- Reset mid-read:
  - Stimulus: read granted in cycle N, rst_i=1 in cycle N+1.
  - Required response: rvalid is 0 in cycle N+1, all outputs are 0, and the first tie after reset goes to m0.
- Enables exclusive:
  - Stimulus: random requests, we and lock values for 10k cycles.
  - Required response: mem_wr_en_o & mem_rd_en_o is never 1, there is never more than one gnt_o, and no master waits more than LOCK_MAX cycles while requesting.
